// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences a fixed-latency mul/div, captures the
// result into HI/LO, services mthi/mtlo writes and stalls mfhi/mflo while busy.
//
// state | meaning
// IDLE  | no op in flight; mthi/mtlo writes and new starts are accepted
// RUN   | op in flight; cnt counts down to the capture edge
module hilo_ctrl #(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                op_div,
    input  logic                divisor_zero,
    input  logic [2*DATA_W-1:0] div_z,
    input  logic [2*DATA_W-1:0] mul_z,
    input  logic                hi_wr,
    input  logic                lo_wr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_req,
    output logic [DATA_W-1:0]   hi_out,
    output logic [DATA_W-1:0]   lo_out,
    output logic                busy,
    output logic                done,
    output logic                stall,
    output logic                dz_flag,
    output logic                wr_conflict
);

    localparam int CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_is_div;
    logic             accept;
    logic             dz_start;
    logic             capture;

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        dz_start  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_div && divisor_zero) begin
                        dz_start = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            hi_out      <= '0;
            lo_out      <= '0;
            cnt         <= '0;
            op_is_div   <= 1'b0;
            done        <= 1'b0;
            dz_flag     <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            done <= capture | dz_start;

            if (dz_start)              dz_flag <= 1'b1;
            else if (accept && op_div) dz_flag <= 1'b0;

            if (accept) begin
                op_is_div <= op_div;
                cnt       <= op_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Software writes only land while idle; a write racing an op is lost.
            if (state == IDLE) begin
                if (hi_wr) hi_out <= wr_data;
                if (lo_wr) lo_out <= wr_data;
            end else if (hi_wr || lo_wr) begin
                wr_conflict <= 1'b1;
            end

            // Divider packs quotient high, but architecturally LO holds the quotient.
            if (capture) begin
                if (op_is_div) begin
                    lo_out <= div_z[2*DATA_W-1:DATA_W];
                    hi_out <= div_z[DATA_W-1:0];
                end else begin
                    hi_out <= mul_z[2*DATA_W-1:DATA_W];
                    lo_out <= mul_z[DATA_W-1:0];
                end
            end
        end
    end

    assign busy  = (state == RUN);
    assign stall = busy & rd_req;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: expected HI/LO pushed at each start and popped
// when done pulses; latency, stall, dz and write-conflict behaviour checked inline.
module tb_hilo_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic           clock = 1'b0;
    logic           clear, start, op_div, divisor_zero;
    logic [2*W-1:0] div_z, mul_z;
    logic           hi_wr, lo_wr, rd_req;
    logic [W-1:0]   wr_data;
    logic [W-1:0]   hi_out, lo_out;
    logic           busy, done, stall, dz_flag, wr_conflict;

    res_t         sb[$];
    logic [W-1:0] exp_hi, exp_lo;
    int           checks = 0;
    int           errors = 0;

    hilo_ctrl #(.DATA_W(W), .DIV_CYCLES(32), .MUL_CYCLES(4)) dut (
        .clock(clock), .clear(clear), .start(start), .op_div(op_div),
        .divisor_zero(divisor_zero), .div_z(div_z), .mul_z(mul_z),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data), .rd_req(rd_req),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
        .stall(stall), .dz_flag(dz_flag), .wr_conflict(wr_conflict)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic is_div, input logic dz, input logic [W-1:0] rhi,
                            input logic [W-1:0] rlo);
        start        = 1'b1;
        op_div       = is_div;
        divisor_zero = dz;
        if (!(is_div && dz)) sb.push_back('{hi: rhi, lo: rlo});
        step();
        start        = 1'b0;
        divisor_zero = 1'b0;
    endtask

    // act: 0 none, 1 mtlo write mid-run, 2 second start mid-run
    task automatic wait_done(input string tag, input int exp_n, input int act, input int act_at);
        int   n = 0;
        res_t e;
        while (busy === 1'b1 && n < 200) begin
            n++;
            rd_req = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "_stall_busy"}, 64'(stall), 64'(rd_req));
            if (n == act_at && act == 1) begin
                lo_wr   = 1'b1;
                wr_data = 32'h0000_1234;
            end
            if (n == act_at && act == 2) begin
                start  = 1'b1;
                op_div = 1'b0;
            end
            @(posedge clock);
            #1;
            lo_wr  = 1'b0;
            start  = 1'b0;
            if (n == act_at && act == 1) begin
                chk({tag, "_lo_kept"}, 64'(lo_out), 64'(exp_lo));
                chk({tag, "_conflict"}, 64'(wr_conflict), 64'd1);
            end
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
        chk({tag, "_done"}, 64'(done), 64'd1);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_hi"}, 64'(hi_out), 64'(e.hi));
                chk({tag, "_lo"}, 64'(lo_out), 64'(e.lo));
                exp_hi = e.hi;
                exp_lo = e.lo;
            end
        end
        rd_req = 1'b1;
        #1;
        chk({tag, "_stall_idle"}, 64'(stall), 64'd0);
        rd_req = 1'b0;
    endtask

    initial begin
        int seen_done;
        clear = 1'b1; start = 1'b0; op_div = 1'b0; divisor_zero = 1'b0;
        div_z = '0; mul_z = '0; hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0; rd_req = 1'b0;
        exp_hi = '0; exp_lo = '0;
        step();
        step();
        clear = 1'b0;
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_flags", {60'd0, busy, done, dz_flag, wr_conflict}, 64'd0);

        // 1: div 100/7
        div_z = {32'd14, 32'd2};
        start_op(1'b1, 1'b0, 32'd2, 32'd14);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 32, 0, 0);
        chk("t1_dz", 64'(dz_flag), 64'd0);
        step();
        chk("t1_done_once", 64'(done), 64'd0);

        // 2: mul
        mul_z = 64'h0000_0001_0000_0000;
        start_op(1'b0, 1'b0, 32'd1, 32'd0);
        wait_done("t2", 4, 0, 0);

        // 3: divide by zero, issued in the done cycle of the mul
        start_op(1'b1, 1'b1, '0, '0);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_dz", 64'(dz_flag), 64'd1);
        chk("t3_hi", 64'(hi_out), 64'(exp_hi));
        chk("t3_lo", 64'(lo_out), 64'(exp_lo));
        step();
        chk("t3_done_once", 64'(done), 64'd0);
        start_op(1'b1, 1'b0, 32'd2, 32'd14);
        chk("t3_dz_cleared", 64'(dz_flag), 64'd0);
        wait_done("t3b", 32, 0, 0);

        // 4: mthi in IDLE, mtlo during RUN
        hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
        step();
        hi_wr = 1'b0;
        exp_hi = 32'hDEAD_BEEF;
        chk("t4_mthi", 64'(hi_out), 64'(exp_hi));
        chk("t4_no_conflict", 64'(wr_conflict), 64'd0);
        mul_z = 64'hAAAA_BBBB_CCCC_DDDD;
        start_op(1'b0, 1'b0, 32'hAAAA_BBBB, 32'hCCCC_DDDD);
        wait_done("t4", 4, 1, 2);
        chk("t4_conflict_sticky", 64'(wr_conflict), 64'd1);

        // 5: second start mid-run is ignored
        div_z = {32'd5, 32'd3};
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        wait_done("t5", 32, 2, 10);
        step();
        chk("t5_done_once", 64'(done), 64'd0);

        // 6: clear mid-div abandons the op
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        repeat (9) step();
        chk("t6_busy_before", 64'(busy), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        sb.delete();
        exp_hi = '0;
        exp_lo = '0;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_hilo", {hi_out, lo_out}, 64'd0);
        chk("t6_flags", {61'd0, done, dz_flag, wr_conflict}, 64'd0);
        seen_done = 0;
        repeat (40) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("t6_no_late_done", 64'(seen_done), 64'd0);
        div_z = {32'd14, 32'd2};
        start_op(1'b1, 1'b0, 32'd2, 32'd14);
        wait_done("t6b", 32, 0, 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Downstream consumer of the divider's 64-bit result {Q,R}; also consumes the multiplier's 64-bit product.
- Sequences a multi-cycle mul/div operation: counts the fixed latency, holds busy, then captures the result into the architectural HI/LO registers.
- Services mthi/mtlo writes and produces the pipeline stall for mfhi/mflo reads issued while an operation is in flight.

Parameters:
- DATA_W, 32, width of HI, LO and wr_data; results are 2*DATA_W.
- DIV_CYCLES, 32, cycles from accepted div start to HI/LO capture (>=1).
- MUL_CYCLES, 4, cycles from accepted mul start to HI/LO capture (>=1).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request a mul/div operation.
- op_div  in  1  1 = divide, 0 = multiply; sampled with start.
- divisor_zero  in  1  divisor == 0; sampled with start when op_div=1.
- div_z  in  2*DATA_W  divider result: [63:32] = quotient, [31:0] = remainder.
- mul_z  in  2*DATA_W  product: [63:32] = high word, [31:0] = low word.
- hi_wr  in  1  mthi write enable.
- lo_wr  in  1  mtlo write enable.
- wr_data  in  DATA_W  mthi/mtlo data.
- rd_req  in  1  mfhi/mflo issued this cycle.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse after completion.
- stall  out  1  combinational: busy & rd_req.
- dz_flag  out  1  divide-by-zero flag.
- wr_conflict  out  1  sticky: hi_wr/lo_wr dropped while busy.

Behaviour:
- Reset (clear=1 at an edge):
  - hi_out = lo_out = 0; busy = done = dz_flag = wr_conflict = 0; FSM = IDLE.
  - clear wins over every other input, including mid-operation. An in-flight op is abandoned with no capture and no done pulse.
- FSM states:
  - IDLE:
    - start=1, op_div=1, divisor_zero=1: stay IDLE; next cycle done=1 and dz_flag=1; HI/LO unchanged.
    - start=1, otherwise: latch op_div; load cnt = (op_div ? DIV_CYCLES : MUL_CYCLES) - 1; go RUN; busy=1 from the next cycle. A successful div start clears dz_flag.
  - RUN:
    - cnt != 0: cnt decrements.
    - cnt == 0, div: lo <= div_z[63:32] (quotient), hi <= div_z[31:0] (remainder).
    - cnt == 0, mul: hi <= mul_z[63:32], lo <= mul_z[31:0].
    - On capture: go IDLE; busy=0 and done=1 in the following cycle.
- Latency: start accepted at edge E0 -> busy high over cycles E0..E(N-1) -> capture at edge EN. N = DIV_CYCLES or MUL_CYCLES. New HI/LO are visible, with done=1, in the cycle after EN.
- div_z and mul_z are sampled only at the capture edge. Upstream holds its operands stable for the full op.
- start while busy (RUN): ignored; no restart, no queue.
- hi_wr/lo_wr:
  - In IDLE: written at the edge; hi_wr and lo_wr together write the same wr_data to both registers.
  - In RUN: dropped; wr_conflict set. The same applies in the capture cycle.
- start together with hi_wr/lo_wr in IDLE: the write is applied and the op starts. The op's later capture overwrites that write.
- stall = busy & rd_req. hi_out/lo_out are always the registered values.
- done is high for exactly one cycle per completed or dz-terminated op.
- No back-to-back overlap: start arriving in the done cycle is accepted (FSM is IDLE).

Test Plan:
1. Reset, then div start with div_z = {32'd14, 32'd2} (100/7): busy high 32 cycles; then lo_out=14, hi_out=2, done pulses exactly once, dz_flag=0.
2. Mul start with mul_z = 64'h0000_0001_0000_0000: after 4 cycles hi_out=1, lo_out=0; stall=1 for every rd_req cycle while busy, 0 after.
3. Div start with divisor_zero=1: no busy; next cycle done=1, dz_flag=1, HI/LO keep their prior values. A following valid div clears dz_flag.
4. In IDLE hi_wr=1 with wr_data=0xDEADBEEF: hi_out=0xDEADBEEF next cycle. During RUN, lo_wr=1 with 0x1234: lo_out unchanged, wr_conflict=1.
5. Second start pulsed mid-RUN: ignored; capture still occurs at the original cycle; only one done pulse.
6. clear asserted at cycle 10 of a div: next cycle busy=0, HI/LO=0, no done pulse; a later start behaves as in test 1.
